// File: rtl/multicycle_core_pkg.sv
// Shared definitions for the multi-cycle 16-bit-ISA core: opcodes, FSM
// state encoding and instruction field layout.
package multicycle_core_pkg;

  // 3-bit major opcodes in instr[15:13]
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_JALR = 3'b100;
  localparam logic [2:0] OP_LUI  = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_LW   = 3'b111;

  // FSM state encoding
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Instruction field bit positions
  localparam int F_OP_LO  = 13;
  localparam int F_RA_LO  = 10;
  localparam int F_RB_LO  = 7;
  localparam int F_RC_LO  = 0;
  localparam int F_IMM7_LO  = 0;
  localparam int F_IMM10_LO = 0;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rc;
    logic [6:0] imm7;
    logic [9:0] imm10;
  } instr_f_t;

  // Slice a raw instruction word into its named fields
  function automatic instr_f_t split_instr(input logic [15:0] ir);
    instr_f_t f;
    f.op    = ir[F_OP_LO    +: 3];
    f.ra    = ir[F_RA_LO    +: 3];
    f.rb    = ir[F_RB_LO    +: 3];
    f.rc    = ir[F_RC_LO    +: 3];
    f.imm7  = ir[F_IMM7_LO  +: 7];
    f.imm10 = ir[F_IMM10_LO +: 10];
    return f;
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 8 x DATA_W register file: three combinational read ports, one synchronous
// write port, r0 hardwired to zero, synchronous clear on reset.
module core_regfile
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ra_addr,
  input  logic [2:0]        rb_addr,
  input  logic [2:0]        rc_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rc_data,
  input  logic              we,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [7:0][DATA_W-1:0] regs;

  // Storage; writes to r0 are dropped so regs[0] stays at its reset value
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (we && (wr_addr != 3'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // r0 reads as zero regardless of storage contents
  always_comb begin
    ra_data = (ra_addr == 3'd0) ? '0 : regs[ra_addr];
    rb_data = (rb_addr == 3'd0) ? '0 : regs[rb_addr];
    rc_data = (rc_addr == 3'd0) ? '0 : regs[rc_addr];
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core for the 16-bit, 3-bit-opcode ISA (plus LW and HALT).
// FETCH -> DECODE -> EXEC [-> MEM] -> FETCH; HALT is terminal until reset.
// Instruction and data memory are reached through req/ack handshakes with
// an arbitrary number of wait states.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted
);

  logic [2:0]        state;
  logic [15:0]       ir;
  instr_f_t          f;

  // operands latched in DECODE
  logic [DATA_W-1:0] op_a, op_b, op_c;
  logic [DATA_W-1:0] rf_a, rf_b, rf_c;

  logic [DATA_W-1:0] imm7_x, lui_v, link_v, alu_res, rf_wd;
  logic [PC_W-1:0]   pc_inc, pc_br, pc_next;
  logic              is_mem, is_halt, wb_en, rf_we;

  assign f = split_instr(ir);

  // ---------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------
  assign imm7_x  = {{(DATA_W-7){f.imm7[6]}}, f.imm7};
  assign lui_v   = DATA_W'({f.imm10, 6'b0});
  assign pc_inc  = pc + 1'b1;                   // wraps at 2^PC_W
  assign pc_br   = pc_inc + imm7_x[PC_W-1:0];   // truncated, wraps
  assign link_v  = DATA_W'(pc_inc);
  assign is_mem  = (f.op == OP_SW) || (f.op == OP_LW);
  assign is_halt = (f.op == OP_JALR) && (f.imm7 != 7'd0);

  // ALU result, writeback enable and next pc for the non-memory opcodes
  always_comb begin
    alu_res = '0;
    wb_en   = 1'b0;
    pc_next = pc_inc;
    case (f.op)
      OP_ADD:  begin alu_res = op_b + op_c;    wb_en = 1'b1; end
      OP_ADDI: begin alu_res = op_b + imm7_x;  wb_en = 1'b1; end
      OP_NAND: begin alu_res = ~(op_b & op_c); wb_en = 1'b1; end
      OP_LUI:  begin alu_res = lui_v;          wb_en = 1'b1; end
      OP_BEQ:  pc_next = (op_a == op_b) ? pc_br : pc_inc;
      OP_JALR: begin
        if (is_halt) begin
          pc_next = pc;
        end else begin
          // op_b was captured in DECODE, so rA == rB still jumps to old rB
          alu_res = link_v;
          wb_en   = 1'b1;
          pc_next = op_b[PC_W-1:0];
        end
      end
      default: ;
    endcase
  end

  // Register writeback: ALU ops in EXEC, loads when the data ack arrives
  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_res;
    if (state == ST_EXEC && wb_en) begin
      rf_we = 1'b1;
    end else if (state == ST_MEM && dmem_ack && !dmem_we) begin
      rf_we = 1'b1;
      rf_wd = dmem_rdata;
    end
  end

  core_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (f.ra),
    .rb_addr (f.rb),
    .rc_addr (f.rc),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .rc_data (rf_c),
    .we      (rf_we),
    .wr_addr (f.ra),
    .wr_data (rf_wd)
  );

  // ---------------------------------------------------------------------
  // Handshake outputs. Requests are pure state decodes, so they drop the
  // cycle after the ack moves the FSM on; reset forces them low at once.
  // ---------------------------------------------------------------------
  assign imem_req  = (state == ST_FETCH) && !reset;
  assign imem_addr = pc;
  assign dmem_req  = (state == ST_MEM) && !reset;

  // Retire marks the cycle an instruction completes (HALT included)
  assign retire = !reset &&
                  (((state == ST_EXEC) && !is_mem) ||
                   ((state == ST_MEM) && dmem_ack));

  // Main FSM, pc and registered data-side request fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_we    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_a  <= rf_a;
          op_b  <= rf_b;
          op_c  <= rf_c;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_mem) begin
            dmem_addr  <= op_b + imm7_x;
            dmem_wdata <= op_a;
            dmem_we    <= (f.op == OP_SW);
            state      <= ST_MEM;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            pc    <= pc_next;
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            pc      <= pc_inc;
            dmem_we <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: behavioural imem/dmem responders with
// programmable wait states, a store scoreboard and retire-cycle tracking.
module tb_multicycle_core;

  localparam int DATA_W = 32;
  localparam int PC_W   = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              imem_req, imem_ack = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_rdata = '0;
  logic              dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [PC_W-1:0]   pc;
  logic              retire, halted;

  multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } store_t;

  logic [15:0]       imem [1024];
  logic [DATA_W-1:0] dmem [256];
  store_t            exp_st[$];
  int                retq[$];
  int                reqlen[$];
  int                total = 0, bad = 0;
  int                cyc = 0;
  int                imem_wait = 0, dmem_wait = 0;
  bit                manual = 1'b0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic [6:0] imm);
    return {op, a, b, imm};
  endfunction

  function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, 4'b0, c};
  endfunction

  // cycle counter: cycle 1 is the first cycle after reset release
  initial forever begin
    @(posedge clk);
    if (!reset) cyc++;
  end

  // retire monitor
  initial forever begin
    @(negedge clk);
    if (retire) retq.push_back(cyc + 1);
  end

  // instruction memory responder
  initial begin
    int iw = 0;
    forever begin
      @(posedge clk); #2;
      if (!manual) begin
        if (imem_req) begin
          if (iw == imem_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = imem[imem_addr];
            iw = 0;
          end else begin
            imem_ack = 1'b0;
            iw++;
          end
        end else begin
          imem_ack = 1'b0;
          iw = 0;
        end
      end
    end
  end

  // data memory responder with store scoreboard
  initial begin
    int dw = 0;
    store_t e;
    forever begin
      @(posedge clk); #2;
      if (dmem_req) begin
        if (dw == dmem_wait) begin
          dmem_ack = 1'b1;
          reqlen.push_back(dw + 1);
          dw = 0;
          if (dmem_we) begin
            dmem[dmem_addr[7:0]] = dmem_wdata;
            if (exp_st.size() == 0) begin
              chk("store_unexpected", dmem_addr, '1);
            end else begin
              e = exp_st.pop_front();
              chk("store_addr", dmem_addr, e.addr);
              chk("store_data", dmem_wdata, e.data);
            end
          end else begin
            dmem_rdata = dmem[dmem_addr[7:0]];
          end
        end else begin
          dmem_ack = 1'b0;
          dw++;
        end
      end else begin
        dmem_ack = 1'b0;
        dw = 0;
      end
    end
  end

  task automatic wait_ret(input int n);
    int b = 0;
    while (retq.size() < n && b < 500) begin
      @(negedge clk); #1;
      b++;
    end
    chk("wait_retire", 32'(retq.size() >= n), 32'd1);
  endtask

  initial begin
    int b;
    int seen;
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // phase 1 program
    imem[0]  = ri (3'b001, 3'd1, 3'd0, 7'd5);     // ADDI r1,r0,5
    imem[1]  = ri (3'b001, 3'd2, 3'd0, 7'h7D);    // ADDI r2,r0,-3
    imem[2]  = rrr(3'b000, 3'd3, 3'd1, 3'd2);     // ADD  r3,r1,r2
    imem[3]  = ri (3'b110, 3'd3, 3'd0, 7'h10);    // SW   r3 -> [0x10]
    imem[4]  = ri (3'b110, 3'd1, 3'd0, 7'd4);     // SW   r1 -> [4]
    imem[5]  = ri (3'b111, 3'd4, 3'd0, 7'd4);     // LW   r4 <- [4]
    imem[6]  = ri (3'b110, 3'd4, 3'd0, 7'h11);    // SW   r4 -> [0x11]
    imem[7]  = ri (3'b011, 3'd1, 3'd2, 7'h7F);    // BEQ  r1,r2,-1 (not taken)
    imem[8]  = {3'b101, 3'd1, 10'h3FF};           // LUI  r1,0x3FF
    imem[9]  = ri (3'b001, 3'd0, 3'd1, 7'd1);     // ADDI r0,r1,1 (dropped)
    imem[10] = ri (3'b110, 3'd1, 3'd0, 7'h12);    // SW   r1 -> [0x12]
    imem[11] = ri (3'b110, 3'd0, 3'd0, 7'h13);    // SW   r0 -> [0x13]
    imem[12] = ri (3'b001, 3'd6, 3'd0, 7'h20);    // ADDI r6,r0,0x20
    imem[13] = ri (3'b100, 3'd5, 3'd6, 7'd0);     // JALR r5,r6
    imem[32] = ri (3'b110, 3'd5, 3'd0, 7'h14);    // SW   r5 -> [0x14]
    imem[33] = ri (3'b100, 3'd0, 3'd0, 7'd1);     // HALT

    exp_st.push_back('{addr: 32'h10, data: 32'd2});
    exp_st.push_back('{addr: 32'h4,  data: 32'd5});
    exp_st.push_back('{addr: 32'h11, data: 32'd5});
    exp_st.push_back('{addr: 32'h12, data: 32'h0000FFC0});
    exp_st.push_back('{addr: 32'h13, data: 32'd0});
    exp_st.push_back('{addr: 32'h14, data: 32'd14});

    imem_wait = 0;
    dmem_wait = 2;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_pc",        pc,         '0);
    chk("rst_imem_req",  imem_req,   '0);
    chk("rst_dmem_req",  dmem_req,   '0);
    chk("rst_retire",    retire,     '0);
    chk("rst_halted",    halted,     '0);
    chk("rst_dmem_addr", dmem_addr,  '0);
    chk("rst_dmem_wdat", dmem_wdata, '0);

    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;

    // ALU ops, zero-wait fetch: retire every 3 cycles
    wait_ret(3);
    chk("ret0_cycle", retq[0], 3);
    chk("ret1_cycle", retq[1], 6);
    chk("ret2_cycle", retq[2], 9);
    @(negedge clk); #1;
    chk("pc_after_3", pc, 10'd3);

    // memory ops with 2 wait states: 6 cycles each, req held 3 cycles
    wait_ret(6);
    chk("sw_latency", retq[4] - retq[3], 6);
    chk("lw_latency", retq[5] - retq[4], 6);
    chk("req_len0", reqlen[0], 3);
    chk("req_len1", reqlen[1], 3);
    chk("req_len2", reqlen[2], 3);

    // not-taken branch at pc 7 -> 8
    wait_ret(8);
    @(negedge clk); #1;
    chk("beq_nt_pc", pc, 10'd8);

    // run to HALT
    b = 0;
    while (!halted && b < 500) begin
      @(negedge clk); #1;
      b++;
    end
    chk("halted", halted, 1'b1);
    chk("halt_retires", retq.size(), 16);
    chk("halt_pc", pc, 10'h21);
    seen = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (imem_req || dmem_req || retire) seen++;
    end
    chk("no_req_after_halt", seen, 0);
    chk("stores_all_seen", exp_st.size(), 0);

    // phase 2: taken branch loop with fetch wait states
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst2_halted", halted, 1'b0);
    chk("rst2_pc", pc, '0);
    imem[0] = ri(3'b001, 3'd1, 3'd0, 7'd1);       // ADDI r1,r0,1
    imem[1] = ri(3'b011, 3'd0, 3'd0, 7'h7F);      // BEQ  r0,r0,-1
    imem_wait = 2;
    retq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;

    wait_ret(3);
    chk("wait_ret0", retq[0], 5);
    chk("loop_ret1", retq[1], 10);
    chk("loop_ret2", retq[2], 15);
    @(negedge clk); #1;
    chk("loop_pc", pc, 10'd1);
    chk("loop_fetch_req", imem_req, 1'b1);

    // reset while a fetch is waiting; ack shows up during the reset cycle
    @(posedge clk); #1;
    manual   = 1'b1;
    imem_ack = 1'b1;
    reset    = 1'b1;
    @(negedge clk); #1;
    chk("rst_ack_req", imem_req, 1'b0);
    chk("rst_ack_retire", retire, 1'b0);
    @(posedge clk); #1;
    reset    = 1'b0;
    imem_ack = 1'b0;
    retq.delete();
    cyc = 0;
    @(negedge clk); #1;
    chk("late_pc", pc, '0);
    chk("late_fetch_req", imem_req, 1'b1);
    chk("late_retire", retire, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("late_no_retire", retq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle 16-bit core. It executes the same 16-bit, 3-bit-opcode ISA extended with LW and HALT, through an explicit FSM. Instruction and data memory sit outside the block and are reached through req/ack handshakes that tolerate any number of wait states. Datapath width and PC width are generic, so the core can drive larger memories and act as the CPU inside a system wrapper.

Parameters:
DATA_W, 16, register/ALU/data-address width; must be >= 16
PC_W, 10, program counter and instruction-address width; must be <= DATA_W
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, rising-edge
reset  in  1  synchronous, active-high
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  16  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_addr  out  DATA_W  data address
dmem_wdata  out  DATA_W  store data
dmem_ack  in  1  data access complete; dmem_rdata valid this cycle for loads
dmem_rdata  in  DATA_W  load data
pc  out  PC_W  current PC
retire  out  1  one-cycle pulse when an instruction completes
halted  out  1  core stopped by HALT

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset: pc = RESET_PC, all 8 registers = 0, state = FETCH, imem_req/dmem_req/dmem_we/retire/halted = 0, dmem_addr/dmem_wdata = 0. Reset overrides everything, including an outstanding request. A late ack arriving after reset is ignored.
- Fields: rA = [12:10], rB = [9:7], rC = [2:0], imm7 = [6:0] sign-extended to DATA_W, imm10 = [9:0].
- r0 reads as 0 and writes to r0 are dropped.
- Opcodes:
  - 000 ADD: rA = rB + rC.
  - 001 ADDI: rA = rB + imm7.
  - 010 NAND: rA = ~(rB & rC).
  - 011 BEQ: if rA == rB then pc = pc + 1 + imm7 (truncated to PC_W, wraps), else pc + 1.
  - 100 JALR: if imm7 == 0 then rA = zero-extended (pc + 1) and pc = rB[PC_W-1:0]; if imm7 != 0 it is HALT.
  - 101 LUI: rA = zero-extended {imm10, 6'b0}.
  - 110 SW: mem[rB + imm7] = rA.
  - 111 LW: rA = mem[rB + imm7].
- Arithmetic: all arithmetic is modulo 2^DATA_W. No flags.
- JALR when rA == rB: pc takes the old rB value and rA is then written with the link.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT.
  - FETCH: imem_req = 1 and imem_addr = pc, held stable until imem_ack. On ack the instruction is latched and the state goes to DECODE.
  - DECODE: operands rA/rB/rC are latched; go to EXEC.
  - EXEC:
    - ADD/ADDI/NAND/LUI/JALR/BEQ: write back, update pc, pulse retire, go to FETCH.
    - SW/LW: dmem_addr and dmem_wdata are registered, go to MEM.
    - HALT: halted = 1, retire pulses, go to HALT.
  - MEM: dmem_req = 1 with dmem_we = (op == SW); address and data held until dmem_ack. On ack, LW writes rA = dmem_rdata; pc = pc + 1, retire pulses, go to FETCH.
  - HALT: terminal; no requests; pc frozen; exits only on reset.
- Latency with ack in the same cycle as req: ALU/branch/jump = 3 cycles, LW/SW = 4 cycles. Each wait cycle adds 1.
- Handshake rules:
  - Acks received while the matching req is 0 are ignored.
  - imem_req and dmem_req are never high together.
  - req deasserts the cycle after ack.
- pc + 1 wraps from 2^PC_W-1 to 0.

Decomposition:
- Package multicycle_core_pkg holds:
  - opcode constants OP_ADD..OP_LW;
  - FSM state encoding;
  - instruction field bit positions.
- Sub-module core_regfile holds the 8 x DATA_W registers: three combinational read ports, one synchronous write port, r0 hardwired to zero, synchronous reset clear.
- ALU, decode and the FSM stay in multicycle_core.

Test Plan:
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2, zero-wait acks -> r3 = 2, retire pulses at cycles 3, 6, 9, final pc = 3.
- SW r1,r0,4 then LW r4,r0,4, with dmem_ack delayed 2 cycles each -> dmem_addr = 4, dmem_wdata = 5, req held 3 cycles per access, r4 = 5, each memory op takes 6 cycles.
- BEQ r0,r0,-1 at pc = 0 with PC_W = 10 -> pc = 0 (loops). Same instruction with r1 != r2 at pc = 7 -> pc = 8.
- JALR r5,r6 with r6 = 0x20 at pc = 3 -> pc = 0x20, r5 = 4. A following JALR with imm7 = 1 -> halted = 1, no further imem_req.
- LUI r1,0x3FF with DATA_W = 32 -> r1 = 0x0000FFC0. A write to r0 leaves r0 reading 0.
- reset asserted while imem_req is waiting for ack, then a late imem_ack -> the next cycle shows pc = RESET_PC, state FETCH, and the stale ack causes no retire.
